timer_digit_loader: RTL

TIMER_DIGIT_LOADER -- requirements
Module: timer_digit_loader

---
 rtl/timer_digit_loader.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/timer_digit_loader.sv
// Keypad digit entry and parallel-load sequencer for a BCD mm:ss cook timer.
// Digits shift in from the right; start commits them to the counters via load_n.
module timer_digit_loader #(
  parameter int LOAD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       cancel,
  input  logic       timer_zero,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       load_n,
  output logic       busy,
  output logic [2:0] digit_count,
  output logic       error
);

  localparam int CW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    LOAD  = 2'd2,
    RUN   = 2'd3
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   load_cnt_r;
  logic            first_run_r;

  logic            key_bad_s;
  logic            can_shift_s;
  logic            start_ok_s;
  logic            last_load_s;

  function automatic logic is_bcd(input logic [3:0] d);
    return (d <= 4'd9);
  endfunction

  assign key_bad_s   = key_valid && !is_bcd(key_digit);
  assign can_shift_s = key_valid && is_bcd(key_digit) && (digit_count < 3'd4);
  // seconds tens above 5 is not a real time, and 00:00 would finish instantly
  assign start_ok_s  = (sec_tens <= 4'd5) &&
                       ({min_tens, min_ones, sec_tens, sec_ones} != 16'd0);
  assign last_load_s = (load_cnt_r == CW'(LOAD_CYCLES - 1));

  // Entry/load/run sequencer with all outputs registered
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_r     <= IDLE;
      load_cnt_r  <= '0;
      first_run_r <= 1'b0;
      min_tens    <= 4'd0;
      min_ones    <= 4'd0;
      sec_tens    <= 4'd0;
      sec_ones    <= 4'd0;
      digit_count <= 3'd0;
      load_n      <= 1'b1;
      busy        <= 1'b0;
      error       <= 1'b0;
    end else begin
      error <= 1'b0;
      if (cancel) begin
        state_r     <= IDLE;
        load_cnt_r  <= '0;
        first_run_r <= 1'b0;
        min_tens    <= 4'd0;
        min_ones    <= 4'd0;
        sec_tens    <= 4'd0;
        sec_ones    <= 4'd0;
        digit_count <= 3'd0;
        load_n      <= 1'b1;
        busy        <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (can_shift_s) begin
              min_tens    <= min_ones;
              min_ones    <= sec_tens;
              sec_tens    <= sec_ones;
              sec_ones    <= key_digit;
              digit_count <= digit_count + 3'd1;
              state_r     <= ENTRY;
            end else if (key_bad_s) begin
              error <= 1'b1;
            end else begin
              state_r <= IDLE;
            end
          end
          ENTRY: begin
            // start outranks any key in the same cycle, accepted or not
            if (start) begin
              if (start_ok_s) begin
                state_r    <= LOAD;
                load_cnt_r <= '0;
                load_n     <= 1'b0;
                busy       <= 1'b1;
              end else begin
                error <= 1'b1;
              end
            end else if (can_shift_s) begin
              min_tens    <= min_ones;
              min_ones    <= sec_tens;
              sec_tens    <= sec_ones;
              sec_ones    <= key_digit;
              digit_count <= digit_count + 3'd1;
            end else if (key_bad_s) begin
              error <= 1'b1;
            end else begin
              state_r <= ENTRY;
            end
          end
          LOAD: begin
            if (last_load_s) begin
              state_r     <= RUN;
              load_n      <= 1'b1;
              first_run_r <= 1'b1;
            end else begin
              load_cnt_r <= load_cnt_r + CW'(1'b1);
            end
          end
          RUN: begin
            // counters may still show zero in the cycle right after the load
            if (first_run_r) begin
              first_run_r <= 1'b0;
            end else if (timer_zero) begin
              state_r     <= IDLE;
              min_tens    <= 4'd0;
              min_ones    <= 4'd0;
              sec_tens    <= 4'd0;
              sec_ones    <= 4'd0;
              digit_count <= 3'd0;
              busy        <= 1'b0;
            end else begin
              state_r <= RUN;
            end
          end
          default: begin
            state_r <= IDLE;
            load_n  <= 1'b1;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
